// File: rtl/dht11_read_scheduler.sv
// Read scheduler for a DHT11 single-wire driver: paces sensor launches, validates
// frames, retries failed reads and answers byte-wide command requests.
module dht11_read_scheduler #(
   parameter int MIN_INTERVAL_CYC = 50_000_000,
   parameter int START_LOW_CYC    = 100,
   parameter int TIMEOUT_CYC      = 2_500_000,
   parameter int MAX_RETRY        = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_cmd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [1:0]  resp_code,
   output logic [7:0]  resp_data,
   output logic        sensor_rst_n,
   input  logic        sensor_done,
   input  logic        sensor_erro,
   input  logic [39:0] sensor_data
);

   localparam int IW = $clog2(MIN_INTERVAL_CYC + 1);
   localparam int SW = $clog2(START_LOW_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [IW-1:0] INTERVAL_MAX = IW'(MIN_INTERVAL_CYC);
   localparam logic [SW-1:0] START_LAST   = SW'(START_LOW_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYC);
   localparam logic [2:0]    RETRY_MAX    = 3'(MAX_RETRY);

   localparam logic [1:0] CODE_OK       = 2'b00;
   localparam logic [1:0] CODE_SENSOR   = 2'b01;
   localparam logic [1:0] CODE_CHECKSUM = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

   localparam logic [1:0] CMD_STATUS    = 2'b10;
   localparam logic [1:0] CMD_RESERVED  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      DISPATCH,
      GUARD,
      START,
      WAIT_DONE,
      CHECK,
      RESPOND
   } state_t;

   state_t          state, state_n;
   logic [IW-1:0]   interval_cnt;
   logic [SW-1:0]   start_cnt;
   logic [TW-1:0]   timeout_cnt;
   logic            done_q;
   logic            done_edge;
   logic            guard_ok;
   logic [1:0]      cmd_q;
   logic [39:0]     frame_q;
   logic            erro_q;
   logic [7:0]      cache_hum;
   logic [7:0]      cache_tmp;
   logic            cache_valid;
   logic [1:0]      last_err;
   logic [2:0]      retry_cnt;
   logic [7:0]      frame_sum;

   logic            launch;
   logic            fail;
   logic [1:0]      fail_code;
   logic            cache_store;
   logic            retry_clear;
   logic            resp_load;
   logic [1:0]      resp_code_n;
   logic [7:0]      resp_data_n;

   assign guard_ok  = (interval_cnt == INTERVAL_MAX);
   assign done_edge = sensor_done & ~done_q;
   assign frame_sum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

   // cmd 00 selects the humidity integer byte, cmd 01 the temperature integer byte
   function automatic logic [7:0] pick_byte(input logic [1:0] cmd,
                                            input logic [7:0] hum,
                                            input logic [7:0] tmp);
      return cmd[0] ? tmp : hum;
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
      state_n     = state;
      launch      = 1'b0;
      fail        = 1'b0;
      fail_code   = CODE_OK;
      cache_store = 1'b0;
      retry_clear = 1'b0;
      resp_load   = 1'b0;
      resp_code_n = CODE_OK;
      resp_data_n = 8'h00;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) state_n = DISPATCH;
         end
         DISPATCH: begin
            if (cmd_q == CMD_RESERVED) begin
               resp_load   = 1'b1;
               resp_code_n = CODE_TIMEOUT;
               state_n     = RESPOND;
            end else if (cmd_q == CMD_STATUS) begin
               resp_load   = 1'b1;
               resp_data_n = {cache_valid, last_err, retry_cnt, guard_ok, 1'b0};
               state_n     = RESPOND;
            end else if (cache_valid && !guard_ok) begin
               resp_load   = 1'b1;
               resp_data_n = pick_byte(cmd_q, cache_hum, cache_tmp);
               state_n     = RESPOND;
            end else begin
               retry_clear = 1'b1;
               state_n     = GUARD;
            end
         end
         GUARD: begin
            if (guard_ok) begin
               launch  = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (start_cnt == START_LAST) state_n = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done_edge) begin
               state_n = CHECK;
            end else if (timeout_cnt == TIMEOUT_MAX) begin
               fail      = 1'b1;
               fail_code = CODE_TIMEOUT;
            end
         end
         CHECK: begin
            if (erro_q) begin
               fail      = 1'b1;
               fail_code = CODE_SENSOR;
            end else if (frame_q[7:0] != frame_sum) begin
               fail      = 1'b1;
               fail_code = CODE_CHECKSUM;
            end else begin
               cache_store = 1'b1;
               resp_load   = 1'b1;
               resp_data_n = pick_byte(cmd_q, frame_q[39:32], frame_q[23:16]);
               state_n     = RESPOND;
            end
         end
         RESPOND: begin
            if (resp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // a failed attempt either relaunches through GUARD or reports its code with zero data
      if (fail) begin
         if (retry_cnt < RETRY_MAX) begin
            state_n = GUARD;
         end else begin
            resp_load   = 1'b1;
            resp_code_n = fail_code;
            resp_data_n = 8'h00;
            state_n     = RESPOND;
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state        <= IDLE;
         interval_cnt <= '0;
         start_cnt    <= '0;
         timeout_cnt  <= '0;
         done_q       <= 1'b0;
         cmd_q        <= 2'b00;
         erro_q       <= 1'b0;
         cache_valid  <= 1'b0;
         last_err     <= CODE_OK;
         retry_cnt    <= 3'd0;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_code    <= CODE_OK;
         resp_data    <= 8'h00;
         sensor_rst_n <= 1'b0;
      end else begin
         state  <= state_n;
         done_q <= sensor_done;

         if (launch)         interval_cnt <= '0;
         else if (!guard_ok) interval_cnt <= interval_cnt + 1'b1;

         if (launch)              start_cnt <= '0;
         else if (state == START) start_cnt <= start_cnt + 1'b1;

         if (launch) timeout_cnt <= '0;
         else if (state == WAIT_DONE && timeout_cnt != TIMEOUT_MAX)
            timeout_cnt <= timeout_cnt + 1'b1;

         if (state == IDLE && req_valid && req_ready) cmd_q <= req_cmd;
         if (state == WAIT_DONE && done_edge)         erro_q <= sensor_erro;

         if (cache_store) begin
            cache_valid <= 1'b1;
            last_err    <= CODE_OK;
         end
         if (fail) begin
            last_err <= fail_code;
            if (retry_cnt < RETRY_MAX) retry_cnt <= retry_cnt + 3'd1;
         end
         if (retry_clear) retry_cnt <= 3'd0;

         if (resp_load) begin
            resp_code <= resp_code_n;
            resp_data <= resp_data_n;
         end

         // handshake and driver-reset outputs are registered from the next state
         req_ready    <= (state_n == IDLE);
         resp_valid   <= (state_n == RESPOND);
         sensor_rst_n <= (state_n != START);
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: frame and cache data need no reset; they are only read once qualified by state or cache_valid.
      if (state == WAIT_DONE && done_edge) frame_q <= sensor_data;
      if (cache_store) begin
         cache_hum <= frame_q[39:32];
         cache_tmp <= frame_q[23:16];
      end
   end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Directed bench for dht11_read_scheduler with a behavioural DHT11 driver model.
module tb_dht11_read_scheduler;

   localparam int MIN_I   = 1000;
   localparam int START_L = 4;
   localparam int TMO     = 500;
   localparam int RETRY   = 2;
   localparam int FRAME_DELAY = 300;

   localparam logic [39:0] GOOD_FRAME = 40'h3A_00_19_00_53;
   localparam logic [39:0] BAD_FRAME  = 40'h3A_00_19_00_54;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_cmd;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_code;
   logic [7:0]  resp_data;
   logic        sensor_rst_n;
   logic        sensor_done = 1'b0;
   logic        sensor_erro = 1'b0;
   logic [39:0] sensor_data = '0;

   dht11_read_scheduler #(
      .MIN_INTERVAL_CYC (MIN_I),
      .START_LOW_CYC    (START_L),
      .TIMEOUT_CYC      (TMO),
      .MAX_RETRY        (RETRY)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_cmd      (req_cmd),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_code    (resp_code),
      .resp_data    (resp_data),
      .sensor_rst_n (sensor_rst_n),
      .sensor_done  (sensor_done),
      .sensor_erro  (sensor_erro),
      .sensor_data  (sensor_data)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // driver model: mode 0 good frame, 1 bad checksum, 2 never completes
   int mode = 0;
   int drv_timer = 0;
   always @(negedge clock) begin
      if (!sensor_rst_n) begin
         drv_timer   = 0;
         sensor_done = 1'b0;
      end else begin
         drv_timer++;
         if (drv_timer == FRAME_DELAY && mode != 2) begin
            sensor_data = (mode == 1) ? BAD_FRAME : GOOD_FRAME;
            sensor_erro = 1'b0;
            sensor_done = 1'b1;
         end
      end
   end

   // launch monitor: cycle of each falling edge, width of each low pulse, last release
   int   fall_cyc[$];
   int   low_w[$];
   int   rise_cyc = 0;
   int   low_run  = 0;
   logic rst_prev = 1'b0;
   always @(negedge clock) begin
      if (rst_prev && !sensor_rst_n) begin
         fall_cyc.push_back(cyc);
         low_run = 0;
      end
      if (!sensor_rst_n) low_run++;
      if (!rst_prev && sensor_rst_n) begin
         low_w.push_back(low_run);
         rise_cyc = cyc;
      end
      rst_prev = sensor_rst_n;
   end

   int errors = 0;
   int checks = 0;
   int resp_wait;
   int resp_cyc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_monitor();
      fall_cyc.delete();
      low_w.delete();
   endtask

   task automatic do_req(input logic [1:0] cmd);
      int n = 0;
      req_valid = 1'b1;
      req_cmd   = cmd;
      while (!req_ready && n < 100) begin
         tick();
         n++;
      end
      check("req_accept", req_ready, 1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input int budget,
                            input logic [1:0] code, input logic [7:0] data);
      int n = 0;
      while (!resp_valid && n < budget) begin
         tick();
         n++;
      end
      resp_wait = n;
      resp_cyc  = cyc;
      check({tag, "_valid"}, resp_valid, 1);
      check({tag, "_code"}, resp_code, code);
      check({tag, "_data"}, resp_data, data);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, "_drop"}, resp_valid, 0);
   endtask

   function automatic logic gaps_ok();
      for (int i = 1; i < fall_cyc.size(); i++)
         if (fall_cyc[i] - fall_cyc[i-1] < MIN_I) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic widths_ok();
      for (int i = 0; i < low_w.size(); i++)
         if (low_w[i] != START_L) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int rst_cyc;
      int first_gap;
      int n;
      logic stable;
      logic seen;

      req_valid  = 1'b0;
      req_cmd    = 2'b00;
      resp_ready = 1'b0;

      // reset values
      repeat (5) tick();
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_code", resp_code, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_sensor_rst_n", sensor_rst_n, 0);

      // 1: first read waits for the power-up interval
      reset   = 1'b0;
      rst_cyc = cyc;
      tick();
      tick();
      clear_monitor();
      do_req(2'b01);
      wait_resp("t1", 3000, 2'b00, 8'h19);
      check("t1_launches", fall_cyc.size(), 1);
      first_gap = (fall_cyc.size() > 0) ? fall_cyc[0] - rst_cyc : -1;
      check("t1_powerup_wait", first_gap >= MIN_I, 1);
      check("t1_low_width", (low_w.size() > 0) ? low_w[0] : -1, START_L);

      // 2: cache hit without a launch
      clear_monitor();
      do_req(2'b00);
      wait_resp("t2", 10, 2'b00, 8'h3A);
      check("t2_latency", resp_wait <= 2, 1);
      check("t2_no_launch", fall_cyc.size(), 0);

      // 3: persistent checksum error, two retries
      repeat (MIN_I + 100) tick();
      mode = 1;
      clear_monitor();
      do_req(2'b00);
      wait_resp("t3", 6000, 2'b10, 8'h00);
      check("t3_launches", fall_cyc.size(), 3);
      check("t3_spacing", gaps_ok(), 1);
      check("t3_low_width", widths_ok(), 1);
      do_req(2'b10);
      wait_resp("t3_status", 10, 2'b00, 8'hC8);

      // 4: driver never completes
      repeat (MIN_I + 100) tick();
      mode = 2;
      clear_monitor();
      do_req(2'b01);
      wait_resp("t4", 6000, 2'b11, 8'h00);
      check("t4_launches", fall_cyc.size(), 3);
      check("t4_spacing", gaps_ok(), 1);
      check("t4_abort_time", (resp_cyc - rise_cyc >= TMO) && (resp_cyc - rise_cyc <= TMO + 2), 1);
      do_req(2'b10);
      wait_resp("t4_status", 10, 2'b00, 8'hE8);

      // reserved command
      do_req(2'b11);
      wait_resp("t4_reserved", 10, 2'b11, 8'h00);

      // 5: response held under back-pressure
      do_req(2'b00);
      n = 0;
      while (!resp_valid && n < 10) begin
         tick();
         n++;
      end
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!resp_valid || resp_code != 2'b00 || resp_data != 8'h3A || req_ready) stable = 1'b0;
         tick();
      end
      check("t5_stable", stable, 1);
      wait_resp("t5", 10, 2'b00, 8'h3A);
      tick();
      check("t5_idle_ready", req_ready, 1);

      // 6: reset while waiting for the frame
      repeat (MIN_I + 100) tick();
      mode = 0;
      do_req(2'b00);
      n = 0;
      while (sensor_rst_n && n < 100) begin
         tick();
         n++;
      end
      n = 0;
      while (!sensor_rst_n && n < 100) begin
         tick();
         n++;
      end
      check("t6_released", sensor_rst_n, 1);
      repeat (10) tick();
      reset = 1'b1;
      tick();
      check("t6_rst_n_low", sensor_rst_n, 0);
      check("t6_no_resp", resp_valid, 0);
      check("t6_req_ready", req_ready, 0);
      tick();
      reset = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < FRAME_DELAY + 100; i++) begin
         if (resp_valid) seen = 1'b1;
         tick();
      end
      check("t6_no_spurious_resp", seen, 0);
      do_req(2'b10);
      wait_resp("t6_status", 10, 2'b00, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
